// File: rtl/hit_pkg.sv
// rtl/hit_pkg.sv - shared types and barrier map for the hit tracker
// Purpose: player state enum, 11-bit coordinate type and the fixed barrier
//          rectangles (inclusive X0, Y0, X1, Y1) checked against the bullet.
// Ports:   none (package).
package hit_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } state_t;

  // One bit wider than the 10-bit screen inputs so sums never wrap.
  typedef logic [10:0] coord_t;

  localparam int NUM_BARRIERS = 4;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
  } rect_t;

  // Barrier 3 is a wall on the left screen edge (X0 = X1 = 0).
  localparam rect_t [0:NUM_BARRIERS-1] BARRIERS = '{
    '{x0: 11'd340, y0: 11'd230, x1: 11'd360, y1: 11'd250},
    '{x0: 11'd100, y0: 11'd100, x1: 11'd140, y1: 11'd110},
    '{x0: 11'd500, y0: 11'd100, x1: 11'd540, y1: 11'd110},
    '{x0: 11'd0,   y0: 11'd400, x1: 11'd0,   y1: 11'd470}
  };

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - inclusive bullet-versus-rectangle overlap test
// Purpose: combinational check that a square bullet (centre, half-size)
//          touches or overlaps rectangle [x0..x1] x [y0..y1].
// Ports:   i_cx, i_cy  bullet centre
//          i_s         bullet half-size
//          i_pad       extra reach added to the bullet half-size
//          i_x0..i_y1  inclusive rectangle bounds
//          o_hit       overlap (zero-gap contact counts)
import hit_pkg::*;

module box_overlap (
  input  coord_t i_cx,
  input  coord_t i_cy,
  input  coord_t i_s,
  input  coord_t i_pad,
  input  coord_t i_x0,
  input  coord_t i_y0,
  input  coord_t i_x1,
  input  coord_t i_y1,
  output logic   o_hit
);

  // A centred target is passed as a degenerate rectangle (x0 = x1 = centre)
  // with its half-size as i_pad, which reduces to |dx| <= Sb + St without
  // ever forming a subtraction that could go negative.
  logic [11:0] w_reach;
  logic        w_x_ok;
  logic        w_y_ok;

  assign w_reach = {1'b0, i_s} + {1'b0, i_pad};
  assign w_x_ok  = ({1'b0, i_cx} + w_reach >= {1'b0, i_x0}) &&
                   ({1'b0, i_cx} <= {1'b0, i_x1} + w_reach);
  assign w_y_ok  = ({1'b0, i_cy} + w_reach >= {1'b0, i_y0}) &&
                   ({1'b0, i_cy} <= {1'b0, i_y1} + w_reach);
  assign o_hit   = w_x_ok && w_y_ok;

endmodule

// File: rtl/hit_tracker.sv
// rtl/hit_tracker.sv - bullet hit detection, health and invulnerability FSM
// Purpose: detects bullet overlap with this player and the barriers, emits
//          one registered pulse per bullet flight, tracks health and the
//          post-hit invulnerability window.
// Ports:   frame_clk, Reset (sync, active-high)
//          bullet_on, BulletX/Y/S      opposing bullet state
//          TargetX/Y/S                 this player's centre and half-size
//          player_hit, barrier_collision  one-frame pulses to the bullet
//          health, invuln, game_over   player status
import hit_pkg::*;

module hit_tracker #(
  parameter int MAX_HEALTH    = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bullet_on,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] BulletS,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  input  logic [9:0] TargetS,
  output logic       player_hit,
  output logic       barrier_collision,
  output logic [2:0] health,
  output logic       invuln,
  output logic       game_over
);

  state_t      r_state, w_state_next;
  logic [2:0]  r_health, w_health_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic        r_armed, w_armed_next;
  logic        r_player_hit, r_barrier_collision;

  coord_t      w_bx, w_by, w_bs, w_tx, w_ty, w_ts;
  logic        w_target_ov;
  logic [NUM_BARRIERS-1:0] w_barrier_ov;
  logic        w_eval, w_target_hit, w_player_pulse, w_barrier_pulse;

  assign w_bx = {1'b0, BulletX};
  assign w_by = {1'b0, BulletY};
  assign w_bs = {1'b0, BulletS};
  assign w_tx = {1'b0, TargetX};
  assign w_ty = {1'b0, TargetY};
  assign w_ts = {1'b0, TargetS};

  box_overlap u_target (
    .i_cx (w_bx), .i_cy (w_by), .i_s (w_bs), .i_pad (w_ts),
    .i_x0 (w_tx), .i_y0 (w_ty), .i_x1 (w_tx), .i_y1 (w_ty),
    .o_hit(w_target_ov)
  );

  for (genvar k = 0; k < NUM_BARRIERS; k++) begin : g_barrier
    box_overlap u_barrier (
      .i_cx (w_bx), .i_cy (w_by), .i_s (w_bs), .i_pad (11'd0),
      .i_x0 (BARRIERS[k].x0), .i_y0 (BARRIERS[k].y0),
      .i_x1 (BARRIERS[k].x1), .i_y1 (BARRIERS[k].y1),
      .o_hit(w_barrier_ov[k])
    );
  end

  assign w_eval          = bullet_on && r_armed;
  assign w_target_hit    = w_eval && w_target_ov;
  // A dead player no longer absorbs bullets; the barrier test still runs.
  assign w_player_pulse  = w_target_hit && (r_state != DEAD);
  assign w_barrier_pulse = w_eval && (|w_barrier_ov) && !w_player_pulse;

  always_comb begin
    w_state_next  = r_state;
    w_health_next = r_health;
    w_cnt_next    = r_cnt;
    w_armed_next  = r_armed;

    if (!bullet_on)
      w_armed_next = 1'b1;
    else if (w_player_pulse || w_barrier_pulse)
      w_armed_next = 1'b0;

    case (r_state)
      ALIVE: begin
        if (w_target_hit) begin
          if (r_health <= 3'd1) begin
            w_health_next = 3'd0;
            w_state_next  = DEAD;
          end else begin
            w_health_next = r_health - 3'd1;
            w_cnt_next    = 8'(INVULN_FRAMES);
            w_state_next  = INVULN;
          end
        end
      end
      INVULN: begin
        // Leaving on the edge where the counter lands on zero.
        if (r_cnt <= 8'd1) begin
          w_cnt_next   = 8'd0;
          w_state_next = ALIVE;
        end else begin
          w_cnt_next = r_cnt - 8'd1;
        end
      end
      DEAD: begin
      end
      default: w_state_next = ALIVE;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      r_state             <= ALIVE;
      r_health            <= 3'(MAX_HEALTH);
      r_cnt               <= 8'd0;
      r_armed             <= 1'b1;
      r_player_hit        <= 1'b0;
      r_barrier_collision <= 1'b0;
    end else begin
      r_state             <= w_state_next;
      r_health            <= w_health_next;
      r_cnt               <= w_cnt_next;
      r_armed             <= w_armed_next;
      r_player_hit        <= w_player_pulse;
      r_barrier_collision <= w_barrier_pulse;
    end
  end

  assign player_hit        = r_player_hit;
  assign barrier_collision = r_barrier_collision;
  assign health            = r_health;
  assign invuln            = (r_state == INVULN);
  assign game_over         = (r_state == DEAD);

endmodule

// File: doc/hit_tracker.md
HIT_TRACKER -- requirements
Module: hit_tracker

Interface
REQ-001 Parameter MAX_HEALTH, default 3, SHALL set the health loaded at reset (range 1..7).
REQ-002 Parameter INVULN_FRAMES, default 60, SHALL set the frames of invulnerability after a damaging hit (range 1..255).
REQ-003 frame_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 bullet_on  input  1  SHALL indicate the opposing bullet is in flight.
REQ-006 BulletX, BulletY, BulletS  input  10 each  SHALL be the bullet centre and half-size.
REQ-007 TargetX, TargetY, TargetS  input  10 each  SHALL be this player's centre and half-size.
REQ-008 player_hit  output  1  SHALL be a one-frame pulse meaning the bullet struck this player; it feeds the bullet's player_hit input.
REQ-009 barrier_collision  output  1  SHALL be a one-frame pulse meaning the bullet struck a barrier; it feeds the bullet's barrier_collision input.
REQ-010 health  output  3  SHALL be the remaining health.
REQ-011 invuln  output  1  SHALL be high while in state INVULN, for sprite blinking.
REQ-012 game_over  output  1  SHALL be high while in state DEAD.

Function
REQ-013 Target overlap SHALL be true when |BulletX-TargetX| <= BulletS+TargetS and |BulletY-TargetY| <= BulletS+TargetS, with all arithmetic done in 11 bits so no wrap occurs.
REQ-014 Barrier k overlap SHALL be true when BulletX+BulletS >= X0[k], BulletX <= X1[k]+BulletS, BulletY+BulletS >= Y0[k] and BulletY <= Y1[k]+BulletS, using inclusive bounds and 11-bit arithmetic.
REQ-015 A bounding edge touching with zero gap SHALL count as an overlap.
REQ-016 Overlaps SHALL be evaluated only when bullet_on=1 and armed=1.
REQ-017 Outputs SHALL be registered: an overlap sampled at edge N SHALL drive its pulse high for exactly the interval from edge N to edge N+1.
REQ-018 If the target and a barrier overlap in the same frame, player_hit SHALL win and barrier_collision SHALL stay 0.
REQ-019 Any pulse SHALL clear armed.
REQ-020 armed SHALL set again on the first edge that samples bullet_on=0.
REQ-021 One bullet flight SHALL therefore produce at most one pulse.
REQ-022 State machine ALIVE, INVULN, DEAD — ALIVE + target hit: pulse player_hit and decrement health; if the new health is 0, go to DEAD, otherwise go to INVULN and load the counter with INVULN_FRAMES.
REQ-023 State machine — INVULN: decrement the counter every frame and return to ALIVE on the frame the counter reaches 0.
REQ-024 In INVULN, a target hit SHALL still pulse player_hit so the bullet is consumed, but health SHALL not change and the counter SHALL not reload.
REQ-025 DEAD SHALL be terminal until Reset.
REQ-026 In DEAD, player_hit SHALL be held 0, while barrier detection continues.
REQ-027 health SHALL never underflow below 0.

Reset
REQ-028 On Reset=1 at an edge: state=ALIVE, health=MAX_HEALTH, counter=0, armed=1, and player_hit, barrier_collision, invuln and game_over all 0.
REQ-029 Reset SHALL override any simultaneous hit, including a reset asserted mid-INVULN or in DEAD.

Structure
REQ-030 Package hit_pkg SHALL hold: the state enum; NUM_BARRIERS=4; the barrier rectangle constant array (X0, Y0, X1, Y1 per barrier); and the 11-bit coordinate typedef.
REQ-031 Combinational sub-module box_overlap SHALL implement the inclusive rectangle test.
REQ-032 box_overlap SHALL be instantiated once for the target and NUM_BARRIERS times for the barriers.

Verification
REQ-033 Direct hit: target (320,240,S=8), bullet (330,240,S=4), bullet_on=1 → player_hit=1 for one frame, health 3→2, invuln=1 for 60 frames then 0.
REQ-034 Edge touch and miss: bullet (332,240,S=4) against the same target → hit; bullet (333,240,S=4) → no pulse, health unchanged.
REQ-035 Re-arm: the bullet stays overlapping for 5 frames with bullet_on=1 → exactly one pulse; then bullet_on=0 for one frame and overlap again after invuln expires → a second pulse, health 2→1.
REQ-036 Simultaneous overlap: bullet overlaps the target and barrier 0 together → player_hit=1, barrier_collision=0.
REQ-037 Barrier only: bullet overlaps barrier 2 → barrier_collision=1 for one frame, health unchanged.
REQ-038 Death then reset: three damaging hits → health=0, game_over=1, and later overlaps give player_hit=0; Reset for one frame → health=3, game_over=0, state ALIVE.
REQ-039 Near-zero coordinates: BulletX=2, BulletS=4 against a barrier with X1=0 → overlap, with no wrap-around false result.
